writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback_if.sv | 33 +++
 rtl/writeback.sv | 107 ++++++++++
 tb/tb_writeback.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// Writeback-stage bundle: memory-stage results in, W-stage state, status and register reads out.
// The master modport drives the stage inputs; the slave modport is the writeback block itself.
interface writeback_if;
    logic        W_stall;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [2:0]  Stat;
    logic        halted;

    modport master (
        output W_stall, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, d_srcA, d_srcB,
        input  d_rvalA, d_rvalB, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, Stat, halted
    );

    modport slave (
        input  W_stall, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, d_srcA, d_srcB,
        output d_rvalA, d_rvalB, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, Stat, halted
    );
endinterface

// File: rtl/writeback.sv
// Y86-64 writeback stage: W pipeline register, 15x64 register file, sticky halt, status output.
// Latency: W loads one edge after m_*, register file commits on the following edge; reads are combinational.
// Backpressure: W_stall, a halt, or a faulting W instruction freezes W. Optional retire counter: WB_RETIRE_CNT_EN.
module writeback (
    input  logic       clk,
    input  logic       rst_n,
    writeback_if.slave wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] I_NOP = 4'h1;
    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    logic [2:0]  w_stat;
    logic [3:0]  w_icode;
    logic [63:0] w_valE;
    logic [63:0] w_valM;
    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic        halted_q;
    logic [63:0] rf [15];

    logic w_fault;
    logic load_en;
    logic commit;
    logic we_e;
    logic we_m;

    always_comb begin
        w_fault = (w_stat == S_HLT) || (w_stat == S_ADR) || (w_stat == S_INS);
        // A faulting instruction stays in W so Stat keeps reporting it after the halt.
        load_en = !wb.W_stall && !halted_q && !w_fault;
        commit  = (w_stat == S_AOK) && !halted_q;
        // popq %rsp: when both destinations match, the memory value wins.
        we_e    = commit && (w_dstE != RNONE) && (w_dstE != w_dstM);
        we_m    = commit && (w_dstM != RNONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_stat   <= S_AOK;
            w_icode  <= I_NOP;
            w_valE   <= '0;
            w_valM   <= '0;
            w_dstE   <= RNONE;
            w_dstM   <= RNONE;
            halted_q <= 1'b0;
        end else begin
            if (load_en) begin
                w_stat  <= wb.m_stat;
                w_icode <= wb.m_icode;
                w_valE  <= wb.m_valE;
                w_valM  <= wb.m_valM;
                w_dstE  <= wb.m_dstE;
                w_dstM  <= wb.m_dstM;
            end
            if (w_fault) begin
                halted_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (we_e) begin
                rf[w_dstE] <= w_valE;
            end
            if (we_m) begin
                rf[w_dstM] <= w_valM;
            end
        end
    end

    // No bypass: a read in the same cycle as a write sees the old contents.
    assign wb.d_rvalA = (wb.d_srcA == RNONE) ? 64'd0 : rf[wb.d_srcA];
    assign wb.d_rvalB = (wb.d_srcB == RNONE) ? 64'd0 : rf[wb.d_srcB];

    assign wb.W_stat  = w_stat;
    assign wb.W_icode = w_icode;
    assign wb.W_valE  = w_valE;
    assign wb.W_valM  = w_valM;
    assign wb.W_dstE  = w_dstE;
    assign wb.W_dstM  = w_dstM;
    assign wb.Stat    = (w_stat == S_BUB) ? S_AOK : w_stat;
    assign wb.halted  = halted_q;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if ((w_stat == S_AOK) && (w_icode != I_NOP) && !halted_q && !wb.W_stall) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: architectural model checked every cycle plus literal expectations.
module tb_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_if wb ();
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
    writeback dut (.clk(clk), .rst_n(rst_n), .wb(wb), .retire_cnt(retire_cnt));
`else
    writeback dut (.clk(clk), .rst_n(rst_n), .wb(wb));
`endif

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Architectural state the outputs must reflect.
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic [63:0] e_valE, e_valM;
    logic [3:0]  e_dstE, e_dstM;
    logic        e_halted;
    logic [63:0] e_rf [15];
    logic [63:0] e_retired;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        e_stat = 3'd1; e_icode = 4'd1; e_valE = '0; e_valM = '0;
        e_dstE = 4'hF; e_dstM = 4'hF; e_halted = 1'b0; e_retired = '0;
        for (int i = 0; i < 15; i++) e_rf[i] = '0;
    endfunction

    function automatic logic [63:0] e_read(logic [3:0] src);
        return (src == 4'hF) ? 64'd0 : e_rf[src];
    endfunction

    // Advance one rising edge: retire what sits in W, then accept the memory stage if W may move.
    task automatic tick();
        logic [63:0] rf_n [15];
        logic [2:0]  st_n;  logic [3:0] ic_n;  logic [63:0] ve_n, vm_n;
        logic [3:0]  de_n, dm_n;  logic hl_n;  logic [63:0] rc_n;
        bit faulty;
        faulty = (e_stat == 3'd2) || (e_stat == 3'd3) || (e_stat == 3'd4);
        for (int i = 0; i < 15; i++) rf_n[i] = e_rf[i];
        st_n = e_stat; ic_n = e_icode; ve_n = e_valE; vm_n = e_valM;
        de_n = e_dstE; dm_n = e_dstM; hl_n = e_halted || faulty; rc_n = e_retired;
        if (e_stat == 3'd1 && !e_halted) begin
            if (e_dstE != 4'hF) rf_n[e_dstE] = e_valE;
            if (e_dstM != 4'hF) rf_n[e_dstM] = e_valM;
            if (e_icode != 4'd1 && !wb.W_stall) rc_n = e_retired + 64'd1;
        end
        if (!wb.W_stall && !e_halted && !faulty) begin
            st_n = wb.m_stat; ic_n = wb.m_icode; ve_n = wb.m_valE; vm_n = wb.m_valM;
            de_n = wb.m_dstE; dm_n = wb.m_dstM;
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 15; i++) e_rf[i] = rf_n[i];
            e_stat = st_n; e_icode = ic_n; e_valE = ve_n; e_valM = vm_n;
            e_dstE = de_n; e_dstM = dm_n; e_halted = hl_n; e_retired = rc_n;
        end
    endtask

    task automatic set_m(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        wb.m_stat = st; wb.m_icode = ic; wb.m_valE = ve; wb.m_valM = vm;
        wb.m_dstE = de; wb.m_dstM = dm;
    endtask

    task automatic bubble();
        set_m(3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_halted", {63'd0, wb.halted}, 64'd0);
        check("async_stat", {61'd0, wb.Stat}, 64'd1);
        for (int i = 0; i < 15; i++) begin
            wb.d_srcA = i[3:0];
            #1;
            check("async_reg_zero", wb.d_rvalA, 64'd0);
        end
        tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("W_stat", {61'd0, wb.W_stat}, {61'd0, e_stat});
            check("W_icode", {60'd0, wb.W_icode}, {60'd0, e_icode});
            check("W_valE", wb.W_valE, e_valE);
            check("W_valM", wb.W_valM, e_valM);
            check("W_dstE", {60'd0, wb.W_dstE}, {60'd0, e_dstE});
            check("W_dstM", {60'd0, wb.W_dstM}, {60'd0, e_dstM});
            check("Stat", {61'd0, wb.Stat}, (e_stat == 3'd0) ? 64'd1 : {61'd0, e_stat});
            check("halted", {63'd0, wb.halted}, {63'd0, e_halted});
            check("d_rvalA", wb.d_rvalA, e_read(wb.d_srcA));
            check("d_rvalB", wb.d_rvalB, e_read(wb.d_srcB));
`ifdef WB_RETIRE_CNT_EN
            check("retire_cnt", retire_cnt, e_retired);
`endif
        end
    end

    initial begin
        wb.W_stall = 1'b0; wb.d_srcA = 4'd0; wb.d_srcB = 4'hF;
        bubble();
        model_reset();
        #1;
        chk_en = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        check("rst_W_stat", {61'd0, wb.W_stat}, 64'd1);
        check("rst_W_icode", {60'd0, wb.W_icode}, 64'd1);
        check("rst_W_dstE", {60'd0, wb.W_dstE}, 64'hF);
        check("rst_halted", {63'd0, wb.halted}, 64'd0);

        // Retire sequence: OPq, irmovq, nop, rmmovq, halt.
        set_m(3'd1, 4'd6, 64'd5, 64'd0, 4'd0, 4'hF);   tick();
        set_m(3'd1, 4'd3, 64'd9, 64'd0, 4'd1, 4'hF);   tick();
        bubble();                                       tick();
        set_m(3'd1, 4'd4, 64'd0, 64'd0, 4'hF, 4'hF);   tick();
        set_m(3'd2, 4'd0, 64'd0, 64'd0, 4'hF, 4'hF);   tick();
        set_m(3'd1, 4'd6, 64'd1, 64'd0, 4'd3, 4'hF);
        for (int i = 0; i < 4; i++) tick();
        check("halt_flag", {63'd0, wb.halted}, 64'd1);
        check("halt_stat", {61'd0, wb.Stat}, 64'd2);
        wb.d_srcA = 4'd1;
        #1;
        check("halt_reg1", wb.d_rvalA, 64'd9);
`ifdef WB_RETIRE_CNT_EN
        check("retire_three", retire_cnt, 64'd3);
`endif
        async_reset();

        // irmovq to %rdx, then read it back.
        set_m(3'd1, 4'd3, 64'h1234, 64'd0, 4'd2, 4'hF);
        tick();
        bubble();
        check("load_dstE", {60'd0, wb.W_dstE}, 64'd2);
        wb.d_srcA = 4'd2;
        #1;
        check("preedge_read", wb.d_rvalA, 64'd0);
        tick();
        check("reg2_written", wb.d_rvalA, 64'h1234);

        // popq %rsp style: both destinations reg 4.
        set_m(3'd1, 4'd11, 64'h100, 64'hBEEF, 4'd4, 4'd4);
        tick();
        bubble();
        tick();
        wb.d_srcB = 4'd4;
        #1;
        check("popq_reg4", wb.d_rvalB, 64'hBEEF);

        // Stall with changing inputs: W holds, reg6 rewritten with the held value.
        set_m(3'd1, 4'd6, 64'h66, 64'd0, 4'd6, 4'hF);
        tick();
        wb.W_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_m(3'd1, 4'd3, 64'hA0 + 64'(i), 64'd0, 4'd7, 4'hF);
            tick();
        end
        check("stall_valE", wb.W_valE, 64'h66);
        check("stall_dstE", {60'd0, wb.W_dstE}, 64'd6);
        wb.W_stall = 1'b0;
        bubble();
        wb.d_srcA = 4'd6;
        wb.d_srcB = 4'd7;
        #1;
        check("stall_reg6", wb.d_rvalA, 64'h66);
        tick();
        tick();

        // Address fault: no write of reg5, halt, later AOK inputs ignored.
        set_m(3'd3, 4'd5, 64'd7, 64'd0, 4'd5, 4'hF);
        tick();
        set_m(3'd1, 4'd3, 64'h55, 64'd0, 4'd5, 4'hF);
        tick();
        wb.d_srcA = 4'd5;
        #1;
        check("adr_halted", {63'd0, wb.halted}, 64'd1);
        check("adr_stat", {61'd0, wb.Stat}, 64'd3);
        check("adr_reg5", wb.d_rvalA, 64'd0);
        for (int i = 0; i < 3; i++) tick();
        check("adr_stat_held", {61'd0, wb.Stat}, 64'd3);
        check("adr_reg5_held", wb.d_rvalA, 64'd0);
        wb.d_srcB = 4'hF;
        #1;
        check("rnone_read", wb.d_rvalB, 64'd0);

        async_reset();
        bubble();
        tick();
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
